// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / halt controller for an in-order core.
// Produces the PC / IF-ID / ID-EX control enables from the hazard, branch and
// halt indications, sequences halt through RUN -> DRAIN -> HALT, keeps a
// saturating hazard-stall statistic and a sticky watchdog error.
//
// Ports:
//   i_clock, i_reset            clock, asynchronous active-low reset
//   i_valid                     pipeline advance enable (debug step/run)
//   i_hazard, i_branch_taken    hazard and taken-branch indications from ID
//   i_halt_id, i_wb_halt        halt decoded in ID / committed in WB
//   i_resume                    leave HALT
//   i_clear_stats               clear stall counter and error flag
//   o_pc_we, o_ifid_we          PC / IF-ID write enables
//   o_ifid_flush, o_idex_bubble NOP injection into IF/ID and ID/EX
//   o_halted                    core halted (state register decode)
//   o_stall_cycles              saturating count of hazard stall cycles
//   o_stall_err                 sticky watchdog error
module pipeline_ctrl #(
  parameter int unsigned NB_STALL_CNT = 16,
  parameter int unsigned MAX_STALL    = 3,
  parameter int unsigned MAX_DRAIN    = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_hazard,
  input  logic                    i_branch_taken,
  input  logic                    i_halt_id,
  input  logic                    i_wb_halt,
  input  logic                    i_resume,
  input  logic                    i_clear_stats,
  output logic                    o_pc_we,
  output logic                    o_ifid_we,
  output logic                    o_ifid_flush,
  output logic                    o_idex_bubble,
  output logic                    o_halted,
  output logic [NB_STALL_CNT-1:0] o_stall_cycles,
  output logic                    o_stall_err
);

  localparam int unsigned NB_HAZ = $clog2(MAX_STALL + 2);
  localparam int unsigned NB_DRN = $clog2(MAX_DRAIN + 2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [NB_HAZ-1:0]       r_haz_cnt;
  logic [NB_DRN-1:0]       r_drain_cnt;
  logic [NB_STALL_CNT-1:0] r_stall_cycles;
  logic                    r_stall_err;

  logic w_haz_cycle;
  logic w_haz_hit;
  logic w_drain_cycle;
  logic w_drain_hit;

  // Watchdog events fire on the cycle the counter reaches its limit, so the
  // error flag is visible in the very next cycle.
  assign w_haz_cycle   = (r_state == ST_RUN) && i_valid && i_hazard;
  assign w_haz_hit     = w_haz_cycle && (r_haz_cnt == NB_HAZ'(MAX_STALL - 1));
  assign w_drain_cycle = (r_state == ST_DRAIN) && i_valid && !i_wb_halt;
  assign w_drain_hit   = w_drain_cycle && (r_drain_cnt == NB_DRN'(MAX_DRAIN - 1));

  // State, watchdog counters and statistics.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= ST_RUN;
      r_haz_cnt      <= '0;
      r_drain_cnt    <= '0;
      r_stall_cycles <= '0;
      r_stall_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_valid) begin
            if (i_hazard) begin
              if (r_haz_cnt != NB_HAZ'(MAX_STALL)) r_haz_cnt <= r_haz_cnt + NB_HAZ'(1);
            end else begin
              r_haz_cnt <= '0;
              if (i_halt_id) begin
                r_state     <= ST_DRAIN;
                r_drain_cnt <= '0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (i_valid) begin
            if (i_wb_halt) begin
              r_state <= ST_HALT;
            end else if (r_drain_cnt != NB_DRN'(MAX_DRAIN)) begin
              r_drain_cnt <= r_drain_cnt + NB_DRN'(1);
            end
          end
        end
        ST_HALT: begin
          if (i_resume) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase

      // Clear has priority over both increment and error set.
      if (i_clear_stats) begin
        r_stall_cycles <= '0;
        r_stall_err    <= 1'b0;
      end else begin
        if (w_haz_cycle && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + NB_STALL_CNT'(1);
        if (w_haz_hit || w_drain_hit) r_stall_err <= 1'b1;
      end
    end
  end

  // Pipeline enables follow the live hazard input; reset forces them low.
  always_comb begin
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    if (i_reset && i_valid) begin
      case (r_state)
        ST_RUN: begin
          if (i_hazard) begin
            o_idex_bubble = 1'b1;
          end else if (i_halt_id) begin
            o_ifid_we    = 1'b1;
            o_ifid_flush = 1'b1;
          end else begin
            o_pc_we      = 1'b1;
            o_ifid_we    = 1'b1;
            o_ifid_flush = i_branch_taken;
          end
        end
        ST_DRAIN: o_idex_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_halted       = (r_state == ST_HALT);
  assign o_stall_cycles = r_stall_cycles;
  assign o_stall_err    = r_stall_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  logic valid, hazard, branch, halt_id, wb_halt, resume, clr;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, halted, stall_err;
  logic [15:0] stall_cycles;
  logic pc_we2, ifid_we2, ifid_flush2, idex_bubble2, halted2, stall_err2;
  logic [1:0] stall_cycles2;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.NB_STALL_CNT(16), .MAX_STALL(3), .MAX_DRAIN(4)) u_dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_hazard(hazard),
    .i_branch_taken(branch), .i_halt_id(halt_id), .i_wb_halt(wb_halt),
    .i_resume(resume), .i_clear_stats(clr),
    .o_pc_we(pc_we), .o_ifid_we(ifid_we), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_halted(halted),
    .o_stall_cycles(stall_cycles), .o_stall_err(stall_err)
  );

  // Narrow statistics counter to exercise saturation.
  pipeline_ctrl #(.NB_STALL_CNT(2), .MAX_STALL(3), .MAX_DRAIN(4)) u_dut_sat (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_hazard(hazard),
    .i_branch_taken(branch), .i_halt_id(halt_id), .i_wb_halt(wb_halt),
    .i_resume(resume), .i_clear_stats(clr),
    .o_pc_we(pc_we2), .o_ifid_we(ifid_we2), .o_ifid_flush(ifid_flush2),
    .o_idex_bubble(idex_bubble2), .o_halted(halted2),
    .o_stall_cycles(stall_cycles2), .o_stall_err(stall_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  in;   // valid hazard branch halt_id wb_halt resume clear
    logic [4:0]  out;  // pc_we ifid_we ifid_flush idex_bubble halted
    logic [15:0] sc;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] in, input logic [4:0] out,
                              input logic [15:0] sc, input logic err);
    vec_t v;
    v.in = in; v.out = out; v.sc = sc; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {valid, hazard, branch, halt_id, wb_halt, resume, clr} = in;
  endtask

  // Apply inputs just after a rising edge, sample at the falling edge.
  task automatic step(input logic [6:0] in);
    @(posedge clk);
    #1;
    drive(in);
    @(negedge clk);
  endtask

  initial begin
    // valid hazard branch halt_id wb_halt resume clear | pc ifid flush bubble halted
    vecs.push_back(mk(7'b0000000, 5'b00000, 16'd0, 1'b0)); // 0 idle
    vecs.push_back(mk(7'b1000000, 5'b11000, 16'd0, 1'b0)); // 1 advance
    vecs.push_back(mk(7'b1010000, 5'b11100, 16'd0, 1'b0)); // 2 taken branch
    vecs.push_back(mk(7'b1100000, 5'b00010, 16'd0, 1'b0)); // 3 hazard pulse
    vecs.push_back(mk(7'b1000000, 5'b11000, 16'd1, 1'b0)); // 4 counted once
    vecs.push_back(mk(7'b1110000, 5'b00010, 16'd1, 1'b0)); // 5 hazard beats branch
    vecs.push_back(mk(7'b1010000, 5'b11100, 16'd2, 1'b0)); // 6 branch next cycle
    vecs.push_back(mk(7'b1101000, 5'b00010, 16'd2, 1'b0)); // 7 hazard beats halt
    vecs.push_back(mk(7'b0100000, 5'b00000, 16'd3, 1'b0)); // 8 invalid holds
    vecs.push_back(mk(7'b1100000, 5'b00010, 16'd3, 1'b0)); // 9 streak 2
    vecs.push_back(mk(7'b1100000, 5'b00010, 16'd4, 1'b0)); // 10 streak 3
    vecs.push_back(mk(7'b1000000, 5'b11000, 16'd5, 1'b1)); // 11 error set
    vecs.push_back(mk(7'b1100001, 5'b00010, 16'd5, 1'b1)); // 12 clear vs increment
    vecs.push_back(mk(7'b1000000, 5'b11000, 16'd0, 1'b0)); // 13 cleared
    vecs.push_back(mk(7'b1001000, 5'b01100, 16'd0, 1'b0)); // 14 halt in ID
    vecs.push_back(mk(7'b1000010, 5'b00010, 16'd0, 1'b0)); // 15 drain, resume ignored
    vecs.push_back(mk(7'b1100100, 5'b00010, 16'd0, 1'b0)); // 16 drain, wb halt
    vecs.push_back(mk(7'b1000100, 5'b00001, 16'd0, 1'b0)); // 17 halted
    vecs.push_back(mk(7'b0000000, 5'b00001, 16'd0, 1'b0)); // 18 halted, invalid
    vecs.push_back(mk(7'b0000010, 5'b00001, 16'd0, 1'b0)); // 19 resume
    vecs.push_back(mk(7'b1000000, 5'b11000, 16'd0, 1'b0)); // 20 running again
    vecs.push_back(mk(7'b1001000, 5'b01100, 16'd0, 1'b0)); // 21 halt in ID
    vecs.push_back(mk(7'b1000000, 5'b00010, 16'd0, 1'b0)); // 22 drain 1
    vecs.push_back(mk(7'b1000000, 5'b00010, 16'd0, 1'b0)); // 23 drain 2
    vecs.push_back(mk(7'b0000000, 5'b00000, 16'd0, 1'b0)); // 24 drain hold
    vecs.push_back(mk(7'b1000000, 5'b00010, 16'd0, 1'b0)); // 25 drain 3
    vecs.push_back(mk(7'b1000000, 5'b00010, 16'd0, 1'b0)); // 26 drain 4
    vecs.push_back(mk(7'b1000000, 5'b00010, 16'd0, 1'b1)); // 27 watchdog, still drain
    vecs.push_back(mk(7'b1000000, 5'b00010, 16'd0, 1'b1)); // 28 sticky

    // Reset with valid high: pipeline outputs must stay low.
    rst_n = 1'b0;
    drive(7'b1000000);
    #12;
    check("rst_pc_we", 0, int'(pc_we), 0);
    check("rst_ifid_we", 0, int'(ifid_we), 0);
    check("rst_halted", 0, int'(halted), 0);
    check("rst_stall_cycles", 0, int'(stall_cycles), 0);
    check("rst_stall_err", 0, int'(stall_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].in);
      check("pc_we", i, int'(pc_we), int'(vecs[i].out[4]));
      check("ifid_we", i, int'(ifid_we), int'(vecs[i].out[3]));
      check("ifid_flush", i, int'(ifid_flush), int'(vecs[i].out[2]));
      check("idex_bubble", i, int'(idex_bubble), int'(vecs[i].out[1]));
      check("halted", i, int'(halted), int'(vecs[i].out[0]));
      check("stall_cycles", i, int'(stall_cycles), int'(vecs[i].sc));
      check("stall_err", i, int'(stall_err), int'(vecs[i].err));
    end

    // Asynchronous reset in DRAIN, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_bubble", 100, int'(idex_bubble), 0);
    check("async_pc_we", 100, int'(pc_we), 0);
    check("async_err", 100, int'(stall_err), 0);
    check("async_halted", 100, int'(halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(7'b1000000);
    check("post_rst_pc_we", 101, int'(pc_we), 1);
    check("post_rst_bubble", 101, int'(idex_bubble), 0);
    check("post_rst_sc", 101, int'(stall_cycles), 0);
    check("post_rst_err", 101, int'(stall_err), 0);

    // Hazard streak: error visible on the 4th cycle; narrow counter saturates.
    for (int k = 1; k <= 5; k++) begin
      step(7'b1100000);
      check("streak_bubble", 200 + k, int'(idex_bubble), 1);
      check("streak_sc", 200 + k, int'(stall_cycles), k - 1);
      check("streak_err", 200 + k, int'(stall_err), (k >= 4) ? 1 : 0);
    end
    step(7'b1000000);
    check("sat_sc_wide", 206, int'(stall_cycles), 5);
    check("sat_sc_narrow", 206, int'(stall_cycles2), 3);
    check("sat_err", 206, int'(stall_err), 1);
    step(7'b1000001);
    step(7'b1000000);
    check("clr_sc", 207, int'(stall_cycles), 0);
    check("clr_sc_narrow", 207, int'(stall_cycles2), 0);
    check("clr_err", 207, int'(stall_err), 0);
    check("clr_pc_we", 207, int'(pc_we), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NB_STALL_CNT, default 16, width of the stall-cycle statistics counter.
REQ-002 SHALL have parameter MAX_STALL, default 3, maximum consecutive hazard cycles before the error flag is raised.
REQ-003 SHALL have parameter MAX_DRAIN, default 4, maximum cycles in DRAIN before the error flag is raised.
REQ-004 SHALL have ports:
 i_clock  in  1  single clock, all state updates on posedge
 i_reset  in  1  asynchronous, active-low reset
 i_valid  in  1  pipeline advance enable (debug step/run)
 i_hazard  in  1  load-use / branch-operand hazard, combinational from the hazard detector
 i_branch_taken  in  1  branch/jump resolved taken in ID
 i_halt_id  in  1  halt instruction decoded in ID
 i_wb_halt  in  1  halt instruction committed in WB
 i_resume  in  1  leave HALT (debug unit)
 i_clear_stats  in  1  synchronous clear of the stall counter and error flag
 o_pc_we  out  1  PC write enable
 o_ifid_we  out  1  IF/ID register write enable
 o_ifid_flush  out  1  load NOP into IF/ID
 o_idex_bubble  out  1  load NOP into ID/EX
 o_halted  out  1  core halted
 o_stall_cycles  out  NB_STALL_CNT  total hazard stall cycles
 o_stall_err  out  1  sticky watchdog error

Function
REQ-005 SHALL implement FSM states RUN, DRAIN, HALT; o_halted=1 only in HALT (registered from state).
REQ-006 RUN, i_valid=1, i_hazard=1: o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_ifid_flush=0; state stays RUN.
REQ-007 RUN, i_valid=1, i_hazard=0, i_halt_id=0: o_pc_we=1, o_ifid_we=1, o_idex_bubble=0, o_ifid_flush=i_branch_taken.
REQ-008 RUN, i_valid=1, i_hazard=0, i_halt_id=1: o_pc_we=0, o_ifid_we=1, o_ifid_flush=1, o_idex_bubble=0; next state DRAIN.
REQ-009 Priority in RUN: hazard > halt > branch; hazard with branch_taken or halt_id SHALL produce only the stall of REQ-006.
REQ-010 DRAIN, i_valid=1: o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_ifid_flush=0; i_wb_halt=1 -> HALT next cycle.
REQ-011 HALT: all four pipeline enables 0 regardless of i_valid; i_resume=1 -> RUN next cycle; i_resume ignored in RUN/DRAIN.
REQ-012 i_valid=0 in RUN or DRAIN: all four pipeline outputs 0, state, counters and watchdogs hold.
REQ-013 i_wb_halt in RUN or HALT SHALL be ignored.
REQ-014 o_stall_cycles SHALL increment by 1 each RUN cycle with i_valid=1 and i_hazard=1, saturating at all-ones.
REQ-015 Consecutive-hazard counter SHALL count RUN cycles with i_valid & i_hazard, clear on any RUN cycle with i_valid & ~i_hazard, hold when i_valid=0.
REQ-016 When the consecutive-hazard counter reaches MAX_STALL (registered), o_stall_err SHALL set the following cycle and stay set.
REQ-017 Drain counter SHALL clear on DRAIN entry, count valid DRAIN cycles; reaching MAX_DRAIN without i_wb_halt SHALL set o_stall_err; FSM stays in DRAIN.
REQ-018 i_clear_stats=1 SHALL zero o_stall_cycles and o_stall_err next cycle; if an increment coincides, clear wins.

Reset
REQ-019 i_reset=0 SHALL asynchronously force state RUN, o_stall_cycles=0, o_stall_err=0, both watchdog counters 0, o_halted=0.
REQ-020 During reset the pipeline outputs SHALL be 0; reset in DRAIN or HALT SHALL return to RUN with no pending halt.

Verification
REQ-021 i_valid=1, i_hazard pulse 1 cycle -> that cycle pc_we=0, ifid_we=0, idex_bubble=1; o_stall_cycles 0->1; no error.
REQ-022 i_hazard=1 and i_branch_taken=1 same cycle -> stall only, ifid_flush=0; next cycle hazard=0, branch=1 -> ifid_flush=1, pc_we=1.
REQ-023 i_hazard held 3 cycles (MAX_STALL=3) -> o_stall_err=1 on the 4th cycle; i_clear_stats -> error and counter 0.
REQ-024 i_halt_id=1 -> DRAIN; i_wb_halt 2 cycles later -> o_halted=1; i_resume -> RUN, pc_we=1 next valid cycle.
REQ-025 DRAIN with no i_wb_halt for 4 valid cycles -> o_stall_err=1, still DRAIN, o_halted=0.
REQ-026 Assert i_reset=0 mid-DRAIN, between clock edges -> outputs 0 immediately; after release state RUN, counters 0.
